teclado_ps2_rx: RTL and testbench
=================================

TECLADO_PS2_RX -- requirements
Module: teclado_ps2_rx

Interface
REQ-001 Parameter FILT_LEN, default 8: number of consecutive equal samples needed to accept a new ps2c level.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles without a ps2c falling edge mid-frame before the frame is aborted.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port ps2c  input  1  PS/2 keyboard clock, asynchronous.
REQ-006 Port ps2d  input  1  PS/2 keyboard data, asynchronous.
REQ-007 Port port_ID  input  8  PicoBlaze port address.
REQ-008 Port rd_strobe  input  1  PicoBlaze read strobe, one cycle.
REQ-009 Port in_port  output  8  read data to PicoBlaze; combinational mux of port_ID.
REQ-010 Port dato_listo  output  1  high while the FIFO holds at least one code; used as the PicoBlaze interrupt.
REQ-011 Port err_trama  output  1  one-cycle pulse on a dropped frame (stop bit, parity or timeout).

Function
REQ-012 ps2c and ps2d SHALL each pass through a 2-flop synchronizer.
REQ-013 Filtered ps2c SHALL change only after FILT_LEN consecutive equal synchronized samples; a falling edge of filtered ps2c is a bit tick.
REQ-014 The frame FSM SHALL have states IDLE, RECV and CHECK; reset state is IDLE.
REQ-015 IDLE -> RECV on a tick with ps2d=0 (start bit); a tick with ps2d=1 SHALL be ignored.
REQ-016 RECV SHALL shift 10 bits LSB-first (8 data, parity, stop) on ticks, then go to CHECK.
REQ-017 In RECV, TIMEOUT_CYC cycles without a tick SHALL return to IDLE and pulse err_trama.
REQ-018 CHECK SHALL last one cycle and then go to IDLE; stop bit 0 SHALL drop the frame and pulse err_trama.
REQ-019 Prefix 8'hE0 SHALL be consumed and not queued.
REQ-020 Prefix 8'hF0 SHALL set a break flag; the next valid code SHALL be discarded and then the flag cleared.
REQ-021 Every other valid make code SHALL be pushed into a 2-entry FIFO; arrow keys appear as 8'h75/72/6B/74 and F-keys as their raw codes (F1=8'h05, F5=8'h03, F12=8'h07).
REQ-022 Port 8'h0B read: in_port = FIFO head, or 8'h00 if empty; rd_strobe pops the head, taking effect on the next cycle.
REQ-023 Port 8'h0C read: in_port = {5'b0, overflow, full, dato_listo}; rd_strobe on 8'h0C SHALL clear overflow.
REQ-024 Other port_ID values: in_port = 8'h00, no side effects.
REQ-025 Push while full SHALL drop the new code and set sticky overflow.
REQ-026 Push and pop in the same cycle while full SHALL accept both, leaving count 2; if empty, a pop SHALL be ignored and the push accepted.

Reset
REQ-027 Reset low SHALL asynchronously force: FSM IDLE, shift register 0, bit counter 0, timeout counter 0, break flag 0, FIFO empty, overflow 0, filter state 1, dato_listo 0, err_trama 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception resumes at the next start bit after release.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, CHECK SHALL drop frames without odd parity over data+parity and pulse err_trama.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored and no parity logic is built.

Structure
REQ-031 A shared package SHALL hold port addresses (8'h0B, 8'h0C), prefix codes (E0, F0) and the FSM state encoding.
REQ-032 Sub-module ps2_filtro_flanco SHALL contain the synchronizer, glitch filter and falling-edge detector.

Verification
REQ-033 Send frame 8'h05 with good parity -> dato_listo=1; read 8'h0B returns 8'h05; dato_listo=0 one cycle after the read.
REQ-034 Send E0 75, then E0 F0 75 -> exactly one code 8'h75 is queued.
REQ-035 Send 8'h03 with bad parity -> with PS2_PARITY_CHECK_EN: one err_trama pulse and nothing queued; without it: 8'h03 is queued.
REQ-036 Send 8'h05, 8'h06, 8'h04 without reading -> status reads 8'h07; reads return 05 then 06; a status read clears overflow.
REQ-037 Stop ps2c after 4 data bits for TIMEOUT_CYC+1 cycles -> err_trama pulses, FSM is IDLE, and the next full frame 8'h0C is received correctly.
REQ-038 Assert reset low mid-frame, release, send 8'h07 -> only 8'h07 is queued and status reads 8'h01.

Source files
------------

// File: rtl/teclado_ps2_rx_pkg.sv
// Shared constants for the PS/2 keyboard receiver: PicoBlaze port map,
// scan-code prefixes and the frame FSM state encoding.
package teclado_ps2_rx_pkg;

    localparam logic [7:0] PORT_DATOS  = 8'h0B;
    localparam logic [7:0] PORT_ESTADO = 8'h0C;

    localparam logic [7:0] PREF_E0 = 8'hE0;
    localparam logic [7:0] PREF_F0 = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } estado_t;

endpackage

// File: rtl/teclado_ps2_rx_filtro.sv
// PS/2 line conditioning: 2-flop synchronizers on ps2c/ps2d, a glitch filter
// on ps2c and a registered falling-edge tick of the filtered clock.
module ps2_filtro_flanco #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic tick,
    output logic ps2d_s
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    c_sync_q, c_sync_d;
    logic [1:0]    d_sync_q, d_sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // cnt_q counts consecutive samples that disagree with the filtered level;
    // the level flips on the FILT_LEN-th such sample.
    always_comb begin
        c_sync_d = {c_sync_q[0], ps2c};
        d_sync_d = {d_sync_q[0], ps2d};
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        if (c_sync_q[1] == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILT_LEN - 1)) begin
            cnt_d  = '0;
            filt_d = c_sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            c_sync_q <= c_sync_d;
            d_sync_q <= d_sync_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
        end
    end

    assign tick   = tick_q;
    assign ps2d_s = d_sync_q[1];

endmodule

// File: rtl/teclado_ps2_rx.sv
// PS/2 keyboard receiver with a 2-entry scan-code FIFO on PicoBlaze ports
// 0x0B/0x0C. Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module teclado_ps2_rx
    import teclado_ps2_rx_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic [7:0] port_ID,
    input  logic       rd_strobe,
    output logic [7:0] in_port,
    output logic       dato_listo,
    output logic       err_trama,
    output logic [1:0] dbg_estado
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    logic tick, ps2d_s;

    ps2_filtro_flanco #(.FILT_LEN(FILT_LEN)) u_filtro (
        .clk    (clk),
        .reset  (reset),
        .ps2c   (ps2c),
        .ps2d   (ps2d),
        .tick   (tick),
        .ps2d_s (ps2d_s)
    );

    estado_t       state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d;
    logic          err_q, err_d;
    logic [7:0]    cab_q, cab_d;
    logic [7:0]    cola_q, cola_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          listo_q, listo_d;
    logic          lleno_q, lleno_d;

    logic       frame_ok;
    logic       push;
    logic       pop;
    logic       clr_ovf;
    logic [7:0] code;

    assign code    = shift_q[7:0];
    assign pop     = rd_strobe && (port_ID == PORT_DATOS) && (cnt_q != 2'd0);
    assign clr_ovf = rd_strobe && (port_ID == PORT_ESTADO);

    // shift_q after ten LSB-first shifts: [7:0] data, [8] parity, [9] stop.
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = shift_q[9] & (^shift_q[8:0]);
`else
    assign frame_ok = shift_q[9];
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        brk_d     = brk_q;
        err_d     = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && !ps2d_s) begin
                    state_d   = ST_RECV;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end
            end
            ST_RECV: begin
                if (tick) begin
                    shift_d = {ps2d_s, shift_q[9:1]};
                    tmo_d   = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d   = ST_CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_d   = ST_IDLE;
                    err_d     = 1'b1;
                    tmo_d     = '0;
                    bit_cnt_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!frame_ok) begin
                    err_d = 1'b1;
                end else if (code == PREF_E0) begin
                    brk_d = brk_q;
                end else if (code == PREF_F0) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                end else begin
                    push = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Two-entry FIFO: cab_q is the head, cola_q the second slot.
    always_comb begin
        cab_d  = cab_q;
        cola_d = cola_q;
        cnt_d  = cnt_q;
        ovf_d  = clr_ovf ? 1'b0 : ovf_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    cab_d = code;
                    cnt_d = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    cola_d = code;
                    cnt_d  = 2'd2;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                cab_d = cola_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    cab_d = code;
                end else begin
                    cab_d  = cola_q;
                    cola_d = code;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        listo_d = (cnt_d != 2'd0);
        lleno_d = (cnt_d == 2'd2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            err_q     <= 1'b0;
            cab_q     <= '0;
            cola_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            listo_q   <= 1'b0;
            lleno_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            err_q     <= err_d;
            cab_q     <= cab_d;
            cola_q    <= cola_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            listo_q   <= listo_d;
            lleno_q   <= lleno_d;
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (port_ID == PORT_DATOS) begin
            in_port = listo_q ? cab_q : 8'h00;
        end else if (port_ID == PORT_ESTADO) begin
            in_port = {5'b00000, ovf_q, lleno_q, listo_q};
        end
    end

    assign dato_listo = listo_q;
    assign err_trama  = err_q;
    assign dbg_estado = state_q;

endmodule

// File: tb/tb_teclado_ps2_rx.sv
// Bench for teclado_ps2_rx: directed scenarios plus randomized frames,
// checked against a queue-based model of the keyboard protocol.
module tb_teclado_ps2_rx;
    import teclado_ps2_rx_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 300;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] port_ID;
    logic       rd_strobe;
    logic [7:0] in_port;
    logic       dato_listo;
    logic       err_trama;
    logic [1:0] dbg_estado;

    teclado_ps2_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .port_ID    (port_ID),
        .rd_strobe  (rd_strobe),
        .in_port    (in_port),
        .dato_listo (dato_listo),
        .err_trama  (err_trama),
        .dbg_estado (dbg_estado)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    bit         model_valid = 1'b0;
    bit         glitch_en = 1'b0;
    bit         ovf_m = 1'b0;
    bit         brk_m = 1'b0;
    bit         err_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_in(input logic [7:0] p);
        if (p == 8'h0B) return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        if (p == 8'h0C) return {5'b00000, ovf_m, exp_q.size() == 2, exp_q.size() != 0};
        return 8'h00;
    endfunction

    // What the keyboard protocol says must happen to one received frame.
    task automatic model_frame(input logic [7:0] code, input bit par_ok, input bit stop_ok);
        if (!stop_ok || (PAR_EN && !par_ok)) err_exp++;
        else if (code == 8'hE0) begin end
        else if (code == 8'hF0) brk_m = 1'b1;
        else if (brk_m) brk_m = 1'b0;
        else if (exp_q.size() < 2) exp_q.push_back(code);
        else ovf_m = 1'b1;
    endtask

    always @(negedge clk) begin
        if (err_trama === 1'b1) begin
            err_seen++;
            check("err_pulse_width", {31'd0, err_prev}, 32'd0);
        end
        err_prev = err_trama;
        if (model_valid) begin
            check("dato_listo", {31'd0, dato_listo}, {31'd0, exp_q.size() != 0});
            check("in_port", {24'd0, in_port}, {24'd0, model_in(port_ID)});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [10:0] b, input int nbits);
        int l;
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(12);
            ps2d = b[i];
            wait_cyc(2);
            if (glitch_en && $urandom_range(0, 3) == 0) begin
                l = $urandom_range(1, FILT - 1);
                ps2c = 1'b0;
                wait_cyc(l);
                ps2c = 1'b1;
                wait_cyc(11 - l);
            end else begin
                wait_cyc(11);
            end
            ps2c = 1'b0;
            wait_cyc(25);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] code, input bit par_ok, input bit stop_ok);
        logic par;
        par = ~^code;
        if (!par_ok) par = ~par;
        return {stop_ok, par, code, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] code, input bit par_ok, input bit stop_ok);
        model_valid = 1'b0;
        send_bits(make_frame(code, par_ok, stop_ok), 11);
        wait_cyc(10);
        model_frame(code, par_ok, stop_ok);
        check("err_count", err_seen, err_exp);
        model_valid = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] p, output logic [7:0] d);
        port_ID   = p;
        rd_strobe = 1'b1;
        #1;
        d = in_port;
        wait_cyc(1);
        rd_strobe = 1'b0;
        if (p == 8'h0B && exp_q.size() != 0) void'(exp_q.pop_front());
        if (p == 8'h0C) ovf_m = 1'b0;
    endtask

    task automatic drain();
        logic [7:0] d;
        while (exp_q.size() != 0) do_read(8'h0B, d);
        do_read(8'h0C, d);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd_strobe = 1'b0; port_ID = 8'h0C;
        wait_cyc(3);
        check("rst_dato_listo", {31'd0, dato_listo}, 32'd0);
        check("rst_err", {31'd0, err_trama}, 32'd0);
        check("rst_state", {30'd0, dbg_estado}, {30'd0, ST_IDLE});
        check("rst_status", {24'd0, in_port}, 32'h00);
        reset = 1'b1;
        wait_cyc(3);
        model_valid = 1'b1;

        // Single F1 make code, read back and empty.
        send_frame(8'h05, 1'b1, 1'b1);
        check("f1_listo", {31'd0, dato_listo}, 32'd1);
        do_read(8'h0B, rd);
        check("f1_read", {24'd0, rd}, 32'h05);
        check("f1_listo_after", {31'd0, dato_listo}, 32'd0);

        // Extended arrow make then break: one 75 queued.
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        do_read(8'h0C, rd);
        check("arrow_status", {24'd0, rd}, 32'h01);
        do_read(8'h0B, rd);
        check("arrow_code", {24'd0, rd}, 32'h75);
        do_read(8'h0C, rd);
        check("arrow_empty", {24'd0, rd}, 32'h00);

        // Bad parity on F5.
        send_frame(8'h03, 1'b0, 1'b1);
        port_ID = 8'h0C;
        #1;
        check("parity_status", {24'd0, in_port}, PAR_EN ? 32'h00 : 32'h01);
        drain();

        // Overflow: three codes without reading.
        send_frame(8'h05, 1'b1, 1'b1);
        send_frame(8'h06, 1'b1, 1'b1);
        send_frame(8'h04, 1'b1, 1'b1);
        do_read(8'h0C, rd);
        check("ovf_status", {24'd0, rd}, 32'h07);
        #1;
        check("ovf_cleared", {24'd0, in_port}, 32'h03);
        do_read(8'h0B, rd);
        check("ovf_rd1", {24'd0, rd}, 32'h05);
        do_read(8'h0B, rd);
        check("ovf_rd2", {24'd0, rd}, 32'h06);
        do_read(8'h0C, rd);
        check("ovf_empty", {24'd0, rd}, 32'h00);

        // Timeout after four data bits, then a clean frame.
        model_valid = 1'b0;
        send_bits(make_frame(8'hA5, 1'b1, 1'b1), 5);
        wait_cyc(TMO + 1 + 20);
        err_exp++;
        check("tmo_err", err_seen, err_exp);
        check("tmo_state", {30'd0, dbg_estado}, {30'd0, ST_IDLE});
        model_valid = 1'b1;
        send_frame(8'h0C, 1'b1, 1'b1);
        do_read(8'h0B, rd);
        check("tmo_next", {24'd0, rd}, 32'h0C);

        // Reset in the middle of a frame.
        model_valid = 1'b0;
        send_bits(make_frame(8'h55, 1'b1, 1'b1), 4);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(3);
        exp_q.delete(); ovf_m = 1'b0; brk_m = 1'b0;
        check("midrst_state", {30'd0, dbg_estado}, {30'd0, ST_IDLE});
        reset = 1'b1;
        wait_cyc(3);
        send_frame(8'h07, 1'b1, 1'b1);
        do_read(8'h0C, rd);
        check("midrst_status", {24'd0, rd}, 32'h01);
        do_read(8'h0B, rd);
        check("midrst_code", {24'd0, rd}, 32'h07);

        // Randomized traffic with glitches, errors, prefixes and reads.
        glitch_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic [7:0] c;
            case ($urandom_range(0, 9))
                0: c = 8'hE0;
                1: c = 8'hF0;
                2: c = 8'h05;
                3: c = 8'h03;
                4: c = 8'h07;
                5: c = 8'h75;
                6: c = 8'h6B;
                default: c = 8'($urandom_range(0, 255));
            endcase
            send_frame(c, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
            repeat ($urandom_range(0, 2)) do_read(8'h0B, rd);
            if ($urandom_range(0, 3) == 0) do_read(8'h0C, rd);
            port_ID = 8'($urandom_range(0, 255));
            wait_cyc(2);
        end
        drain();
        wait_cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
